ysyx_23060332_regfile_sb: RTL and testbench



---
 rtl/ysyx_23060332_regfile_sb.sv | 123 ++++++++++++
 tb/tb_ysyx_23060332_regfile_sb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060332_regfile_sb.sv
// ysyx_23060332_regfile_sb
//   Integer register file for the NPC core with a built-in write scoreboard.
//   It has NRD combinational read ports, one writeback port and one
//   reservation port. Each register has a small pending-write counter. The
//   issue logic uses the counters to stall on RAW hazards, and the counters
//   allow several in-flight writes to the same register.
//   Register 0 always reads as zero, is never busy, and ignores writes and
//   reservations.
//
//   Optional feature macro: YSYX_23060332_REGFILE_BYPASS_EN
//     When it is defined, a read port whose address matches the active write
//     returns wdata in the same cycle. Its busy bit then shows the counter
//     as it would be after that write's decrement.

module ysyx_23060332_regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NRD   = 2,
    parameter int CNT_W = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ready,
    input  logic                wen,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                flush
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  regs_d [NREG];
    logic [CNT_W-1:0] cnt_q  [NREG];
    logic [CNT_W-1:0] cnt_d  [NREG];

    logic rsv_take;
    logic wr_live;

    // A reservation is accepted only when the counter has room and no flush is active.
    always_comb begin
        rsv_ready = (rsv_addr == '0) || (cnt_q[rsv_addr] != CNT_MAX);
        rsv_take  = rsv_en && rsv_ready && !flush && (rsv_addr != '0);
        wr_live   = wen && (waddr != '0);
    end

    // Next-state data: the writeback updates its register. A flush does not block this.
    always_comb begin
        // NOTE: every combinational output gets a default value first. Without it, a missed branch would infer a latch.
        regs_d = regs_q;
        if (wr_live) begin
            regs_d[waddr] = wdata;
        end
    end

    // Next-state counters: flush clears all counters; otherwise apply reserve (+1) and write (-1, saturating).
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush) begin
                cnt_d[i] = '0;
            end else if (i != 0) begin
                if (rsv_take && (rsv_addr == AW'(i)) && wr_live && (waddr == AW'(i))) begin
                    cnt_d[i] = cnt_q[i];
                end else if (rsv_take && (rsv_addr == AW'(i))) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end else if (wr_live && (waddr == AW'(i)) && (cnt_q[i] != '0)) begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end
            end
        end
    end

    // State registers: a synchronous reset clears both data and counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. Every flop then samples its pre-edge value.
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                // NOTE: the data array is reset on purpose because readers expect all-zero registers after reset. This keeps it in flops rather than RAM macros.
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    // Read ports: combinational lookup with x0 forced to zero, plus an optional write bypass.
    always_comb begin
        logic [AW-1:0] ra;
        ra    = '0;
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = raddr[k*AW +: AW];
            if (ra != '0) begin
`ifdef YSYX_23060332_REGFILE_BYPASS_EN
                if (wr_live && (waddr == ra)) begin
                    rdata[k*XLEN +: XLEN] = wdata;
                    rbusy[k]              = cnt_q[ra] > CNT_ONE;
                end else begin
                    rdata[k*XLEN +: XLEN] = regs_q[ra];
                    rbusy[k]              = cnt_q[ra] != '0;
                end
`else
                rdata[k*XLEN +: XLEN] = regs_q[ra];
                rbusy[k]              = cnt_q[ra] != '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_regfile_sb.sv
// Testbench for ysyx_23060332_regfile_sb with default parameters (NRD=2, CNT_W=2).
// It applies table-driven per-cycle vectors and checks the outputs before each edge.
// Hand-written sequences cover the reset sweep and mid-operation reset.

module tb_ysyx_23060332_regfile_sb;

`ifdef YSYX_23060332_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rsv_ready;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        flush;

    int errors = 0;
    int checks = 0;

    ysyx_23060332_regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        rsv_en;
        logic [4:0]  rsv_addr;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  busy;
        logic        ready;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic re, input logic [4:0] ra_rsv,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic [1:0] eb, input logic er);
        vec_t v;
        v.flush = fl; v.rsv_en = re; v.rsv_addr = ra_rsv;
        v.wen = we; v.waddr = wa; v.wdata = wd;
        v.ra0 = a0; v.ra1 = a1;
        v.rd0 = e0; v.rd1 = e1; v.busy = eb; v.ready = er;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic fl, input logic re, input logic [4:0] ra_rsv,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a0, input logic [4:0] a1);
        rst = r; flush = fl; rsv_en = re; rsv_addr = ra_rsv;
        wen = we; waddr = wa; wdata = wd;
        raddr = {a1, a0};
    endtask

    // Wait to the middle of the cycle so checks see settled combinational outputs.
    task automatic mid_cycle();
        @(negedge clk);
    endtask

    // Take the edge, then move just past it before changing inputs.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state: every register on both ports reads 0, not busy, reservation ready.
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 5'(a), 0, 0, 0, 5'(a), 5'(a));
            mid_cycle();
            check($sformatf("reset_rd0_x%0d", a), rdata[31:0], 32'h0);
            check($sformatf("reset_rd1_x%0d", a), rdata[63:32], 32'h0);
            check($sformatf("reset_busy_x%0d", a), {30'h0, rbusy}, 32'h0);
            check($sformatf("reset_ready_x%0d", a), {31'h0, rsv_ready}, 32'h1);
            next_cycle();
        end

        //   fl re rsva we wa  wdata   ra0 ra1 rd0 / rd1 / busy / ready
        // A write to x0 is discarded.
        add(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 32'h0, 32'h0, 2'b00, 1);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0, 32'h0, 2'b00, 1);
        // x5: reserved in cycle 0 and written 0x1234 in cycle 3; read on port 1.
        add(0, 1, 5, 0, 0, 32'h0,    0, 5, 32'h0, 32'h0, 2'b00, 1);
        add(0, 0, 0, 0, 0, 32'h0,    0, 5, 32'h0, 32'h0, 2'b10, 1);
        add(0, 0, 0, 0, 0, 32'h0,    0, 5, 32'h0, 32'h0, 2'b10, 1);
        add(0, 0, 0, 1, 5, 32'h1234, 0, 5, 32'h0, BYP ? 32'h1234 : 32'h0, BYP ? 2'b00 : 2'b10, 1);
        add(0, 0, 0, 0, 0, 32'h0,    0, 5, 32'h0, 32'h1234, 2'b00, 1);
        // x7: three reservations saturate the counter; the fourth is refused even with a same-cycle write.
        add(0, 1, 7, 0, 0, 32'h0,  7, 0, 32'h0, 32'h0, 2'b00, 1);
        add(0, 1, 7, 0, 0, 32'h0,  7, 0, 32'h0, 32'h0, 2'b01, 1);
        add(0, 1, 7, 0, 0, 32'h0,  7, 0, 32'h0, 32'h0, 2'b01, 1);
        add(0, 1, 7, 1, 7, 32'h77, 7, 0, BYP ? 32'h77 : 32'h0, 32'h0, 2'b01, 0);
        add(0, 0, 7, 0, 0, 32'h0,  7, 0, 32'h77, 32'h0, 2'b01, 1);
        // Two more writes drain x7, which shows the count was exactly 2.
        add(0, 0, 0, 1, 7, 32'h78, 7, 0, BYP ? 32'h78 : 32'h77, 32'h0, 2'b01, 1);
        add(0, 0, 0, 1, 7, 32'h79, 7, 0, BYP ? 32'h79 : 32'h78, 32'h0, BYP ? 2'b00 : 2'b01, 1);
        add(0, 0, 0, 0, 0, 32'h0,  7, 0, 32'h79, 32'h0, 2'b00, 1);
        // x9: a same-cycle reserve and write holds the count; a write at count 0 does not underflow.
        add(0, 1, 9, 0, 0, 32'h0,  0, 9, 32'h0, 32'h0, 2'b00, 1);
        add(0, 1, 9, 1, 9, 32'h99, 0, 9, 32'h0, BYP ? 32'h99 : 32'h0, BYP ? 2'b00 : 2'b10, 1);
        add(0, 0, 0, 0, 0, 32'h0,  0, 9, 32'h0, 32'h99, 2'b10, 1);
        add(0, 0, 0, 1, 9, 32'h9A, 0, 9, 32'h0, BYP ? 32'h9A : 32'h99, BYP ? 2'b00 : 2'b10, 1);
        add(0, 0, 0, 1, 9, 32'h9B, 0, 9, 32'h0, BYP ? 32'h9B : 32'h9A, 2'b00, 1);
        add(0, 0, 0, 0, 0, 32'h0,  0, 9, 32'h0, 32'h9B, 2'b00, 1);
        // Flush: reserve x3 and x4, then flush with a write to x3 and a reservation of x6.
        add(0, 1, 3, 0, 0, 32'h0,  3, 4, 32'h0, 32'h0, 2'b00, 1);
        add(0, 1, 4, 0, 0, 32'h0,  3, 4, 32'h0, 32'h0, 2'b01, 1);
        add(1, 1, 6, 1, 3, 32'hAB, 3, 4, BYP ? 32'hAB : 32'h0, 32'h0, BYP ? 2'b10 : 2'b11, 1);
        add(0, 0, 0, 0, 0, 32'h0,  3, 6, 32'hAB, 32'h0, 2'b00, 1);
        add(0, 0, 0, 0, 0, 32'h0,  4, 5, 32'h0, 32'h1234, 2'b00, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(0, vecs[i].flush, vecs[i].rsv_en, vecs[i].rsv_addr,
                  vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].ra0, vecs[i].ra1);
            mid_cycle();
            check($sformatf("vec%0d_rd0", i), rdata[31:0], vecs[i].rd0);
            check($sformatf("vec%0d_rd1", i), rdata[63:32], vecs[i].rd1);
            check($sformatf("vec%0d_busy", i), {30'h0, rbusy}, {30'h0, vecs[i].busy});
            check($sformatf("vec%0d_ready", i), {31'h0, rsv_ready}, {31'h0, vecs[i].ready});
            next_cycle();
        end

        // Mid-operation reset: write x2, reserve x2, then reset while writing and reserving x2.
        drive(0, 0, 0, 0, 1, 2, 32'h11, 2, 5);
        next_cycle();
        drive(0, 0, 1, 2, 0, 0, 32'h0, 2, 5);
        mid_cycle();
        check("prerst_rd0", rdata[31:0], 32'h11);
        next_cycle();
        drive(1, 0, 1, 2, 1, 2, 32'h55, 2, 5);
        mid_cycle();
        check("prerst_busy", {30'h0, rbusy}, 32'h1);
        next_cycle();
        drive(0, 0, 0, 2, 0, 0, 32'h0, 2, 5);
        mid_cycle();
        check("postrst_rd0_x2", rdata[31:0], 32'h0);
        check("postrst_rd1_x5", rdata[63:32], 32'h0);
        check("postrst_busy", {30'h0, rbusy}, 32'h0);
        check("postrst_ready", {31'h0, rsv_ready}, 32'h1);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
